// File: rtl/spi_slave_word.sv
// spi_slave_word: word-wide SPI slave with auto-incrementing address, streaming read requests and end/abort framing
module spi_slave_word #(
  parameter int WORD_W      = 8,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int ADDR_INC    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              spi_clk,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [WORD_W-1:0] addr,
  output logic [WORD_W-1:0] wdata,
  output logic              wstb,
  output logic              first,
  output logic              rd_req,
  output logic [WORD_W-1:0] rd_addr,
  input  logic [WORD_W-1:0] rd_data,
  output logic              done,
  output logic              abort
);
  localparam int CW = $clog2(WORD_W);
  localparam logic [WORD_W-1:0] INC = WORD_W'(ADDR_INC);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t r_state, w_state_nxt;
  logic [SYNC_STAGES-1:0] r_sclk_sync, r_cs_sync, r_mosi_sync;
  logic r_sclk_q, r_cs_q, r_first_pend;
  logic w_sclk, w_cs, w_mosi, w_rise, w_fall, w_lead, w_trail;
  logic w_active, w_sample, w_shift, w_cs_fall, w_cs_rise, w_wrap;
  logic [CW-1:0] r_bit_cnt, w_bit_cnt_nxt;
  logic [WORD_W-1:0] r_rx, r_tx, r_next_addr, w_word;
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_cs = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
  assign w_rise = w_sclk & ~r_sclk_q;
  assign w_fall = ~w_sclk & r_sclk_q;
  assign w_lead = (CPOL != 0) ? w_fall : w_rise;
  assign w_trail = (CPOL != 0) ? w_rise : w_fall;
  assign w_active = r_state != IDLE;
  assign w_sample = w_active & ((CPHA != 0) ? w_trail : w_lead);
  assign w_shift = w_active & ((CPHA != 0) ? w_lead : w_trail);
  assign w_cs_fall = r_cs_q & ~w_cs & ~w_active;
  assign w_cs_rise = ~r_cs_q & w_cs & w_active;
  assign w_wrap = w_sample & (r_bit_cnt == CW'(WORD_W - 1));
  assign w_bit_cnt_nxt = w_wrap ? '0 : w_sample ? r_bit_cnt + CW'(1) : r_bit_cnt;
  assign w_word = {r_rx[WORD_W-2:0], w_mosi};
  // Pad synchronisers and edge-detect history; CS resets low so a CS still held low after reset never looks like a fresh fall
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_sclk_sync <= {SYNC_STAGES{1'(CPOL)}};
      r_cs_sync   <= '0;
      r_mosi_sync <= '0;
      r_sclk_q    <= 1'(CPOL);
      r_cs_q      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sclk_q    <= w_sclk;
      r_cs_q      <= w_cs;
    end
  // Transaction state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else r_state <= w_state_nxt;
  // Next state: CS framing dominates, word 0 completion moves from address to data phase
  always_comb begin
    w_state_nxt = w_cs_fall ? ADDR : w_cs_rise ? IDLE : (r_state == ADDR && w_wrap) ? DATA : r_state;
  end
  // Shift registers, address tracking and registered strobes
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_bit_cnt    <= '0;
      r_rx         <= '0;
      r_tx         <= '0;
      r_next_addr  <= '0;
      r_first_pend <= 1'b0;
      spi_miso     <= 1'b0;
      spi_miso_oe  <= 1'b0;
      addr         <= '0;
      wdata        <= '0;
      wstb         <= 1'b0;
      first        <= 1'b0;
      rd_req       <= 1'b0;
      rd_addr      <= '0;
      done         <= 1'b0;
      abort        <= 1'b0;
    end else begin
      wstb   <= 1'b0;
      first  <= 1'b0;
      rd_req <= 1'b0;
      done   <= 1'b0;
      abort  <= 1'b0;
      if (w_cs_fall) begin
        r_bit_cnt    <= '0;
        r_first_pend <= 1'b1;
        r_tx         <= (CPHA != 0) ? rd_data : {rd_data[WORD_W-2:0], 1'b0};
        spi_miso     <= (CPHA != 0) ? 1'b0 : rd_data[WORD_W-1];
        spi_miso_oe  <= 1'b1;
      end else begin
        r_bit_cnt <= w_bit_cnt_nxt;
        if (w_sample) r_rx <= w_word;
        if (w_wrap) begin
          rd_req <= 1'b1;
          if (r_state == ADDR) begin
            rd_addr     <= w_word;
            r_next_addr <= w_word;
          end else begin
            wstb         <= 1'b1;
            wdata        <= w_word;
            addr         <= r_next_addr;
            first        <= r_first_pend;
            r_first_pend <= 1'b0;
            rd_addr      <= r_next_addr + INC;
            r_next_addr  <= r_next_addr + INC;
          end
        end
        if (rd_req) r_tx <= rd_data;
        else if (w_shift) begin
          spi_miso <= r_tx[WORD_W-1];
          r_tx     <= {r_tx[WORD_W-2:0], 1'b0};
        end
        if (w_cs_rise) begin
          done        <= w_bit_cnt_nxt == '0;
          abort       <= w_bit_cnt_nxt != '0;
          spi_miso    <= 1'b0;
          spi_miso_oe <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_spi_slave_word.sv
// tb_spi_slave_word: drives six differently parameterised slaves as an SPI master and scores them against a transaction-level model
module tb_spi_slave_word;
  localparam int N = 6;
  localparam int H = 6;
  typedef struct {
    int k;
    int kind;
    logic [15:0] a;
    logic [15:0] d;
    logic f;
  } ev_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mosi = 1'b0;
  logic [N-1:0] sclk, csn, miso_v, oe_v, wstb_v, first_v, rdreq_v, done_v, abort_v;
  logic [15:0] addr_a[N], wdata_a[N], rd_addr_a[N], status_a[N], key_a[N];
  ev_t obs_q[$], exp_q[$];
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = (g == 5) ? 16 : 8;
    localparam int CP = (g == 2 || g == 3) ? 1 : 0;
    localparam int CH = (g == 1 || g == 3) ? 1 : 0;
    localparam int INC = (g == 4) ? 0 : 1;
    logic [W-1:0] a, wd, ra, rdd;
    logic so, soe, ws, fi, rr, dn, ab;
    assign rdd = W'(rr ? (16'(ra) ^ key_a[g]) : status_a[g]);
    spi_slave_word #(.WORD_W(W), .CPOL(CP), .CPHA(CH), .ADDR_INC(INC), .SYNC_STAGES(2)) u_dut (
      .clk(clk), .rst(rst), .spi_clk(sclk[g]), .spi_cs_n(csn[g]), .spi_mosi(mosi),
      .spi_miso(so), .spi_miso_oe(soe), .addr(a), .wdata(wd), .wstb(ws), .first(fi),
      .rd_req(rr), .rd_addr(ra), .rd_data(rdd), .done(dn), .abort(ab)
    );
    assign addr_a[g] = 16'(a);
    assign wdata_a[g] = 16'(wd);
    assign rd_addr_a[g] = 16'(ra);
    assign miso_v[g] = so;
    assign oe_v[g] = soe;
    assign wstb_v[g] = ws;
    assign first_v[g] = fi;
    assign rdreq_v[g] = rr;
    assign done_v[g] = dn;
    assign abort_v[g] = ab;
  end
  function automatic int w_of(input int k);
    return (k == 5) ? 16 : 8;
  endfunction
  function automatic bit cpol_of(input int k);
    return k == 2 || k == 3;
  endfunction
  function automatic bit cpha_of(input int k);
    return k == 1 || k == 3;
  endfunction
  function automatic int inc_of(input int k);
    return (k == 4) ? 0 : 1;
  endfunction
  function automatic logic [15:0] msk(input int k, input logic [15:0] v);
    return (k == 5) ? v : {8'h00, v[7:0]};
  endfunction
  function automatic logic [15:0] rsp(input int k, input logic [15:0] a);
    return msk(k, a ^ key_a[k]);
  endfunction
  // Every DUT output pulse becomes one scoreboard event, in time order
  always @(negedge clk)
    for (int k = 0; k < N; k++) begin
      if (wstb_v[k]) obs_q.push_back(ev_t'{k, 0, addr_a[k], wdata_a[k], first_v[k]});
      else if (first_v[k]) obs_q.push_back(ev_t'{k, 4, 16'h0, 16'h0, 1'b1});
      if (rdreq_v[k]) obs_q.push_back(ev_t'{k, 1, rd_addr_a[k], 16'h0, 1'b0});
      if (done_v[k]) obs_q.push_back(ev_t'{k, 2, 16'h0, 16'h0, 1'b0});
      if (abort_v[k]) obs_q.push_back(ev_t'{k, 3, 16'h0, 16'h0, 1'b0});
    end
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    checks++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic half();
    repeat (H) @(negedge clk);
  endtask
  function automatic logic [63:0] outs(input int k);
    return {9'b0, oe_v[k], miso_v[k], wstb_v[k], first_v[k], rdreq_v[k], done_v[k], abort_v[k], addr_a[k], wdata_a[k], rd_addr_a[k]};
  endfunction
  function automatic logic [63:0] pack(input ev_t e);
    return {8'h00, 8'(e.k), 8'(e.kind), e.a, e.d, 7'b0, e.f};
  endfunction
  // One master transaction: nw whole words then `extra` bits; cut replaces the CS rise with a reset
  task automatic run_txn(input int k, input int nw, input logic [15:0] w[8], input int extra,
                         input logic [15:0] xb, input int gap, input bit cut);
    int wd = w_of(k);
    bit cp = cpol_of(k);
    bit ch = cpha_of(k);
    int inc = inc_of(k);
    logic [15:0] base = msk(k, w[0]);
    logic [15:0] tw, cur;
    csn[k] = 1'b0;
    half();
    for (int b = 0; b < nw * wd + extra; b++) begin
      int j = b / wd;
      int i = wd - 1 - b % wd;
      cur = (j < nw) ? w[j] : xb;
      tw = (j == 0) ? status_a[k] : rsp(k, base + 16'((j - 1) * inc));
      if (ch) begin
        sclk[k] = ~cp;
        mosi = cur[i];
        half();
        chk($sformatf("miso k%0d bit%0d", k, b), {62'b0, oe_v[k], miso_v[k]}, {62'b0, 1'b1, tw[i]});
        sclk[k] = cp;
        half();
      end else begin
        mosi = cur[i];
        half();
        chk($sformatf("miso k%0d bit%0d", k, b), {62'b0, oe_v[k], miso_v[k]}, {62'b0, 1'b1, tw[i]});
        sclk[k] = ~cp;
        half();
        sclk[k] = cp;
      end
    end
    half();
    if (cut) begin
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("outputs in reset", outs(k), 64'h0);
      rst = 1'b0;
      repeat (3) @(negedge clk);
    end
    csn[k] = 1'b1;
    repeat (gap) @(negedge clk);
    for (int j = 0; j < nw; j++) begin
      if (j > 0) exp_q.push_back(ev_t'{k, 0, msk(k, base + 16'((j - 1) * inc)), msk(k, w[j]), j == 1});
      exp_q.push_back(ev_t'{k, 1, msk(k, base + 16'(j * inc)), 16'h0, 1'b0});
    end
    if (!cut) exp_q.push_back(ev_t'{k, (extra == 0) ? 2 : 3, 16'h0, 16'h0, 1'b0});
  endtask
  task automatic check_events(input int k);
    repeat (12) @(negedge clk);
    chk($sformatf("event count k%0d", k), 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
      chk($sformatf("event %0d k%0d", i, k), pack(obs_q[i]), pack(exp_q[i]));
    chk($sformatf("oe idle k%0d", k), 64'(oe_v[k]), 64'h0);
    obs_q.delete();
    exp_q.delete();
  endtask
  initial begin
    logic [15:0] w[8];
    int k, nw, ex;
    sclk = 6'b001100;
    csn = '1;
    for (int i = 0; i < N; i++) begin
      status_a[i] = 16'h0;
      key_a[i] = 16'h0;
    end
    for (int i = 0; i < 8; i++) w[i] = 16'h0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) chk($sformatf("reset outputs k%0d", i), outs(i), 64'h0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    obs_q.delete();
    status_a[0] = 16'($urandom);
    key_a[0] = 16'($urandom);
    w[0] = 16'h10; w[1] = 16'hA5; w[2] = 16'h5A;
    run_txn(0, 3, w, 0, 16'h0, 4, 1'b0);
    check_events(0);
    for (int m = 0; m < 4; m++) begin
      w[0] = 16'($urandom_range(0, 255));
      w[1] = 16'($urandom);
      w[2] = 16'($urandom);
      status_a[m] = 16'hC3;
      key_a[m] = w[0] ^ 16'h3C;
      run_txn(m, 3, w, 0, 16'h0, 4, 1'b0);
      check_events(m);
    end
    w[0] = 16'h20; w[1] = 16'h77;
    run_txn(0, 2, w, 3, 16'($urandom), 4, 1'b0);
    check_events(0);
    w[0] = 16'hFF; w[1] = 16'($urandom); w[2] = 16'($urandom);
    run_txn(0, 3, w, 0, 16'h0, 4, 1'b0);
    check_events(0);
    run_txn(4, 3, w, 0, 16'h0, 4, 1'b0);
    check_events(4);
    status_a[5] = 16'($urandom);
    key_a[5] = 16'($urandom);
    w[0] = 16'h1234; w[1] = 16'hBEEF;
    run_txn(5, 2, w, 0, 16'h0, 4, 1'b0);
    check_events(5);
    w[0] = 16'($urandom); w[1] = 16'($urandom);
    run_txn(0, 1, w, 4, w[1], 4, 1'b1);
    check_events(0);
    w[0] = 16'h10; w[1] = 16'hA5; w[2] = 16'h5A;
    run_txn(0, 3, w, 0, 16'h0, 4, 1'b0);
    check_events(0);
    run_txn(1, 0, w, 0, 16'h0, 4, 1'b0);
    check_events(1);
    w[0] = 16'($urandom); w[1] = 16'($urandom);
    run_txn(0, 2, w, 0, 16'h0, 2, 1'b0);
    w[0] = 16'($urandom); w[1] = 16'($urandom); w[2] = 16'($urandom);
    run_txn(0, 3, w, 0, 16'h0, 4, 1'b0);
    check_events(0);
    for (int r = 0; r < 12; r++) begin
      k = $urandom_range(0, N - 1);
      nw = $urandom_range(0, 4);
      ex = ($urandom_range(0, 2) == 0) ? $urandom_range(1, w_of(k) - 1) : 0;
      status_a[k] = 16'($urandom);
      key_a[k] = 16'($urandom);
      for (int i = 0; i < 8; i++) w[i] = 16'($urandom);
      run_txn(k, nw, w, ex, 16'($urandom), 4, 1'b0);
      check_events(k);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/spi_slave_word.md
Name: spi_slave_word

Overview:
- Parametrised SPI slave that generalises the team's byte-wide SPI register port.
- Adds configurable word width, all four SPI modes, address auto-increment, a per-word read request for streaming MISO data, and explicit end/abort framing.
- Sits between the board SPI pads (via top-level IO cells) and the register/buffer fabric in the clk domain.
- Word 0 of every transaction is the address; each later word is one data word.

Parameters:
- WORD_W, 8: bits per SPI word; also the width of address and data.
- CPOL, 0: idle level of spi_clk.
- CPHA, 0: 0 = sample on leading edge, shift on trailing edge; 1 = shift on leading edge, sample on trailing edge.
- ADDR_INC, 1: added to the address after each data word; 0 = fixed address (FIFO-style).
- SYNC_STAGES, 2: synchroniser depth on spi_clk, spi_cs_n and spi_mosi (minimum 2).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- spi_clk  in  1  SPI clock pad (asynchronous).
- spi_cs_n  in  1  chip select pad, active-low.
- spi_mosi  in  1  SPI data in.
- spi_miso  out  1  SPI data out; drives the IO cell.
- spi_miso_oe  out  1  MISO output enable.
- addr  out  WORD_W  write address, valid with wstb.
- wdata  out  WORD_W  received data word, valid with wstb.
- wstb  out  1  one-cycle pulse per completed data word.
- first  out  1  high with wstb for the first data word of a transaction.
- rd_req  out  1  one-cycle pulse requesting the next word to transmit.
- rd_addr  out  WORD_W  address of the requested word, valid with rd_req.
- rd_data  in  WORD_W  transmit word; captured on CS fall and on the rd_req cycle.
- done  out  1  pulse on CS rise at a word boundary.
- abort  out  1  pulse on CS rise with a partial word pending.

Behaviour:
- **Reset.** All outputs are 0; state is IDLE; counters and shift registers are cleared. Reset mid-transaction drops that transaction: no wstb or done is emitted, and the block waits for the next CS fall.
- **Synchronisers and edges.** Each pad passes through SYNC_STAGES flops, then one registered edge detector.
  - Leading edge = rise if CPOL=0, fall if CPOL=1; trailing edge is the opposite.
  - Sample edge = leading if CPHA=0, else trailing. Shift edge = the other one.
- **Clock ratio.** clk must be at least 8x spi_clk.
- **State machine.** States are IDLE, ADDR and DATA.
  - IDLE -> ADDR on CS fall.
  - ADDR -> DATA on word 0 completion.
  - ADDR/DATA -> IDLE on CS rise.
  - Edge events are ignored in IDLE.
- **CS fall.**
  - bit_cnt=0, word count n=0.
  - Transmit register loads rd_data (status word).
  - spi_miso_oe=1.
  - If CPHA=0, spi_miso = rd_data[WORD_W-1] immediately.
- **Sample edge.** The synchronised mosi shifts into the receive register MSB-first. bit_cnt increments and wraps at WORD_W-1 -> 0; the wrap is "word completion".
- **Shift edge.** spi_miso takes the next transmit bit, MSB-first.
  - With CPHA=1, the first leading edge drives the MSB.
  - With CPHA=0, the trailing edge after a word completion drives the MSB of the newly captured word.
- **Word completion** (actions register on the clk cycle after the sample-edge event):
  - Word 0: base <= received word; rd_req=1 with rd_addr=base; go to DATA.
  - Data word n>=1: wstb=1 with wdata = received word and addr = base + (n-1)*ADDR_INC (mod 2^WORD_W). In the same cycle, rd_req=1 with rd_addr = base + n*ADDR_INC.
  - first=1 only with the wstb for n=1.
  - The transmit register loads rd_data on every rd_req cycle. This gives read-before-write at the same address position.
- **Address wrap.** Addresses wrap modulo 2^WORD_W.
- **CS rise.**
  - bit_cnt==0: done pulse.
  - Otherwise: abort pulse; the partial word is discarded with no wstb.
  - In both cases spi_miso_oe=0 and state goes to IDLE.
- **Simultaneous events.** A sample edge seen in the same cycle as CS rise is processed first. If it completes a word, wstb and rd_req fire, then done.
- **No-data transaction.** CS rise in ADDR with bit_cnt==0 (no words clocked) gives done and no wstb.
- **Back-to-back transactions.** A CS fall one cycle after done starts a fresh transaction; first re-arms.

Test Plan:
1. **Mode 0, WORD_W=8, ADDR_INC=1.** Send 0x10, 0xA5, 0x5A, then CS rise -> wstb twice with (addr,wdata) = (0x10,0xA5), (0x11,0x5A); first only on the first; rd_req with rd_addr 0x10, 0x11, 0x12; done=1, abort=0.
2. **All four CPOL/CPHA modes.** rd_data=0xC3 at CS fall, then 0x3C on the first rd_req -> MISO shows 0xC3 during word 0 and 0x3C during word 1, each bit stable across its sample edge.
3. **Partial word.** Address 0x20, data 0x77, then 3 more bits, then CS rise -> a single wstb (0x20,0x77) and abort=1, done=0.
4. **Address wrap and fixed address.** ADDR_INC=1, address 0xFF, two data words -> addr 0xFF then 0x00. With ADDR_INC=0 -> addr 0xFF for both.
5. **WORD_W=16.** Address 0x1234, data 0xBEEF -> wstb with addr 0x1234 and wdata 0xBEEF.
6. **Reset mid-transaction.** Assert rst after 12 bits -> no wstb and no done; outputs are 0. A following full transaction behaves as in scenario 1.
